// File: rtl/data_shifter_right_pkg.sv
// Shared audio sample widths and types for the codec <-> DSP shifters.
// Feeds parameter defaults of data_shifter_right and data_shifter_left.
package data_shifter_right_pkg;

   localparam int AUDIO_CODEC_W    = 24;
   localparam int AUDIO_DSP_W      = 16;
   localparam int AUDIO_SHIFT      = 8;
   localparam int AUDIO_CLIP_CNT_W = 8;

   typedef logic signed [AUDIO_CODEC_W-1:0] codec_sample_t;
   typedef logic signed [AUDIO_DSP_W-1:0]   dsp_sample_t;

endpackage

// File: rtl/data_shifter_right_sat_round_narrow.sv
// Combinational shift-and-saturate of a pre-rounded sum down to OUT_W bits; zero latency, no backpressure.
// The round-half-up offset is already folded into sum_in so callers can register it separately.
module data_shifter_right_sat_round_narrow #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 16,
   parameter int SHIFT = 8
) (
   input  logic signed [IN_W:0]    sum_in,
   output logic                    clip,
   output logic signed [OUT_W-1:0] value
);

   localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'(2 ** (OUT_W-1) - 1);
   localparam logic signed [IN_W:0] Q_MIN = (IN_W+1)'(-(2 ** (OUT_W-1)));

   logic signed [IN_W:0] shifted;

   always_comb begin
      shifted = sum_in >>> SHIFT;
      clip    = 1'b0;
      value   = shifted[OUT_W-1:0];
      if (shifted > Q_MAX) begin
         clip  = 1'b1;
         value = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (shifted < Q_MIN) begin
         clip  = 1'b1;
         value = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

endmodule

// File: rtl/data_shifter_right.sv
// Narrows signed codec samples to DSP width (round-half-up, saturate); 2-clk latency, 1 sample/clk.
// Full valid/ready backpressure: holds output while stalled, absorbs 2 samples before in_ready drops.
module data_shifter_right
   import data_shifter_right_pkg::*;
#(
   parameter int IN_W  = AUDIO_CODEC_W,
   parameter int OUT_W = AUDIO_DSP_W,
   parameter int SHIFT = AUDIO_SHIFT,
   parameter int CNT_W = AUDIO_CLIP_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enn,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_data,
   input  logic                    out_ready,
   input  logic                    clip_clr,
   output logic [CNT_W-1:0]        clip_count
);

   // One guard bit above IN_W so adding the half-LSB can never wrap.
   localparam logic signed [IN_W:0] ROUND_OFS = (IN_W+1)'(2 ** (SHIFT-1));
   localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

   logic                    s1_valid_q, s1_valid_d;
   logic signed [IN_W:0]    s1_sum_q, s1_sum_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]        clip_count_q, clip_count_d;

   logic                    s2_ready, s1_ready, in_xfer, s2_load;
   logic                    nar_clip;
   logic signed [OUT_W-1:0] nar_value;

   data_shifter_right_sat_round_narrow #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_narrow (
      .sum_in (s1_sum_q),
      .clip   (nar_clip),
      .value  (nar_value)
   );

   always_comb begin
      s2_ready = !out_valid_q || out_ready;
      s1_ready = !s1_valid_q || s2_ready;
      in_ready = enn && rst_n && s1_ready;
      in_xfer  = in_valid && in_ready;
      s2_load  = enn && s1_valid_q && s2_ready;
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_sum_d     = s1_sum_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      clip_count_d = clip_count_q;

      if (in_xfer) begin
         s1_sum_d   = {in_data[IN_W-1], in_data} + ROUND_OFS;
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         out_valid_d = 1'b1;
         out_data_d  = nar_value;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Disabling drops in-flight samples but keeps the level history.
      if (!enn) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end

      if (clip_clr) begin
         clip_count_d = '0;
      end else if (s2_load && nar_clip && (clip_count_q != CNT_MAX)) begin
         clip_count_d = clip_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_sum_q     <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         clip_count_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sum_q     <= s1_sum_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         clip_count_q <= clip_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign clip_count = clip_count_q;

endmodule
